memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter that places the instruction cache and the data cache onto one unified word-wide main memory. It sits directly downstream of both caches and replaces their private memories. Instruction misses are served as four-word bursts assembled into a 128-bit line; data misses and write-backs are served as single-word transfers. Requests are never preempted once started.

## Interface
- Parameters: none; address map fixed (below).
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  synchronous, active-high
- i_read  input  1  instruction-cache block read request, held until i_busywait low
- i_address  input  6  instruction block address
- i_readdata  output  128  assembled line, word k at bits [32k+31:32k]
- i_busywait  output  1  instruction request pending
- d_read, d_write  input  1 each  data-cache word read / write request, mutually exclusive, held until d_busywait low
- d_address  input  6  data block (word) address
- d_writedata  input  32  write word
- d_readdata  output  32  read word
- d_busywait  output  1  data request pending
- mem_read, mem_write  output  1 each  unified memory strobes
- mem_address  output  9  unified word address
- mem_writedata  output  32  write word
- mem_readdata  input  32  read word
- mem_busywait  input  1  memory busy; beat completes on an edge where the strobe is high and mem_busywait low

## Operation
- Address map: instruction word = {1'b0, i_address, beat[1:0]}; data word = {3'b100, d_address}.
- States: IDLE, IFILL, IGAP, DACC, IDONE, DDONE.
- IDLE: if a data request is pending -> DACC; else if i_read -> IFILL with beat=0. Both pending: data wins (see Configuration).
- IFILL: mem_read=1 at beat address. On completion, capture mem_readdata into line word[beat]. If beat<3, increment beat and go to IGAP; on beat 3 -> IDONE.
- IGAP: strobes low for exactly one cycle -> IFILL. Each beat is therefore a distinct memory request.
- DACC: mem_read or mem_write mirrors d_read/d_write; mem_writedata=d_writedata. On completion capture the read word -> DDONE.
- IDONE/DDONE: the matching busywait is low for exactly one cycle with readdata valid; the cache samples it on the next edge; then -> IDLE.
- i_busywait = i_read && state!=IDONE; d_busywait = (d_read||d_write) && state!=DDONE. Both are combinational, so a request asserted in IDLE sees busywait high in the same cycle.
- A request is locked once granted. A request on the other port waits through the whole transaction, including any gap cycles.
- i_readdata and d_readdata hold their last captured value between transactions.

## Timing
- Memory latency L = cycles mem_busywait stays high per beat; L=0 is legal.
- Data access: grant edge -> DACC; L+1 cycles in DACC; 1 DDONE cycle. d_busywait high for L+2 cycles after the request cycle.
- Instruction fill: 4(L+1) IFILL cycles + 3 IGAP cycles + 1 IDONE cycle.
- Minimum one IDLE cycle between consecutive transactions.
- RESET high at an edge: state=IDLE, beat=0, mem_read=mem_write=0, mem_address=0, mem_writedata=0, i_readdata=0, d_readdata=0, round-robin pointer=data. This applies mid-burst too: a partial line is discarded and no busywait-low completion pulse is issued.
- While RESET is high, both busywaits are forced 0.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, the port not served last wins. The last-served pointer updates on entry to IDONE/DDONE.
- Undefined: fixed data-over-instruction priority. A continuous stream of data requests may starve instruction fetch.

## Test plan
- Data write then read, L=2: d_write addr 0x05, data 0xDEADBEEF -> mem_write at address 0x105 for 3 cycles, d_busywait low 1 cycle. Then d_read 0x05 -> d_readdata 0xDEADBEEF.
- Instruction fill, L=1: preload words 0x0C..0x0F = 0x11111111..0x44444444; i_read addr 0x03 -> four beats at 0x00C..0x00F, each separated by 1 gap cycle. i_readdata = 0x44444444_33333333_22222222_11111111 in IDONE. Total 12 cycles from grant to IDONE.
- Simultaneous requests, L=0, macro undefined: data served first, then instruction. With ARB_ROUND_ROBIN_EN and last-served=data: instruction served first.
- Data request arrives during beat 2 of a fill: mem_address never leaves the 0x0xx range until IDONE. DACC starts after one IDLE cycle.
- RESET asserted for 1 cycle during beat 1 of a fill: next edge all strobes 0, state IDLE, i_readdata=0. A re-issued i_read restarts from beat 0.
- L=0 back-to-back data reads at 0x3F and 0x00 -> mem_address 0x13F then 0x100, each access with d_busywait high for exactly 2 cycles.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-wide memory between the instruction cache (4-beat line fills)
// and the data cache (single-word accesses). Optional macro ARB_ROUND_ROBIN_EN alternates grants.
module memory_arbiter (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_read,
  input  logic [5:0]   i_address,
  output logic [127:0] i_readdata,
  output logic         i_busywait,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [5:0]   d_address,
  input  logic [31:0]  d_writedata,
  output logic [31:0]  d_readdata,
  output logic         d_busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [8:0]   mem_address,
  output logic [31:0]  mem_writedata,
  input  logic [31:0]  mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IFILL = 3'd1,
    IGAP  = 3'd2,
    DACC  = 3'd3,
    IDONE = 3'd4,
    DDONE = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [1:0]  beat, beat_next;
  logic [95:0] line;
  logic        d_req;
  logic        grant_data;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data;

  // last_data=1 means the data port was the most recently completed transaction
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_data <= 1'b1;
    end else if (state_next == IDONE && state != IDONE) begin
      last_data <= 1'b0;
    end else if (state_next == DDONE && state != DDONE) begin
      last_data <= 1'b1;
    end
  end

  assign grant_data = d_req & (~i_read | ~last_data);
`else
  assign grant_data = d_req;
`endif

  assign i_busywait = ~RESET & i_read & (state != IDONE);
  assign d_busywait = ~RESET & d_req  & (state != DDONE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      beat       <= 2'd0;
      line       <= '0;
      i_readdata <= '0;
      d_readdata <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      // Beats shift in from the top so word 0 ends up at the bottom after four beats;
      // the visible line only changes once the whole burst has arrived.
      if (state == IFILL && !mem_busywait) begin
        line <= {mem_readdata, line[95:32]};
        if (beat == 2'd3) begin
          i_readdata <= {mem_readdata, line};
        end
      end
      if (state == DACC && d_read && !mem_busywait) begin
        d_readdata <= mem_readdata;
      end
    end
  end

  always_comb begin
    state_next    = state;
    beat_next     = beat;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (grant_data) begin
          state_next = DACC;
        end else if (i_read) begin
          state_next = IFILL;
          beat_next  = 2'd0;
        end
      end
      IFILL: begin
        mem_read    = 1'b1;
        mem_address = {1'b0, i_address, beat};
        if (!mem_busywait) begin
          if (beat == 2'd3) begin
            state_next = IDONE;
          end else begin
            beat_next  = beat + 2'd1;
            state_next = IGAP;
          end
        end
      end
      IGAP: begin
        mem_address = {1'b0, i_address, beat};
        state_next  = IFILL;
      end
      DACC: begin
        mem_read      = d_read;
        mem_write     = d_write;
        mem_address   = {3'b100, d_address};
        mem_writedata = d_writedata;
        if (!mem_busywait) begin
          state_next = DDONE;
        end
      end
      IDONE:   state_next = IDLE;
      DDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Keep the memory quiet while reset is pending so no beat can complete mid-reset
    if (RESET) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: table vectors, multi-cycle corner sequences and
// random single-port traffic checked against a transaction-level model of memory and timing.
module tb_memory_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         i_read;
  logic [5:0]   i_address;
  logic [127:0] i_readdata;
  logic         i_busywait;
  logic         d_read;
  logic         d_write;
  logic [5:0]   d_address;
  logic [31:0]  d_writedata;
  logic [31:0]  d_readdata;
  logic         d_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [8:0]   mem_address;
  logic [31:0]  mem_writedata;
  logic [31:0]  mem_readdata;
  logic         mem_busywait;

  memory_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Unified memory with a per-beat latency of lat cycles
  logic [31:0] mem [512];
  logic        bd_en;
  logic [8:0]  bd_addr;
  logic [31:0] bd_data;
  int          lat;
  int          wcnt;

  assign mem_busywait = (mem_read || mem_write) && (wcnt < lat);
  assign mem_readdata = mem[mem_address];

  always @(posedge CLK) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
    if ((mem_read || mem_write) && mem_busywait) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Bus monitor
  int          strobe_cnt = 0;
  int          rise_cnt = 0;
  bit          prev_strobe = 1'b0;
  logic [8:0]  beat_q [$];

  always @(negedge CLK) begin
    if (mem_read || mem_write) begin
      strobe_cnt <= strobe_cnt + 1;
      if (!prev_strobe) rise_cnt <= rise_cnt + 1;
      if (!mem_busywait) beat_q.push_back(mem_address);
    end
    prev_strobe <= mem_read || mem_write;
  end

  // Reference model state
  logic [31:0] ref_mem [512];
  bit          last_inst;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  function automatic logic [31:0] pre(input int a);
    if (a >= 12 && a <= 15) return 32'h11111111 * 32'(a - 11);
    return 32'hA0000000 + 32'(a) * 32'h00010001;
  endfunction

  function automatic logic [127:0] model_line(input logic [5:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = ref_mem[int'(a) * 4 + k];
    return r;
  endfunction

  function automatic logic [8:0] q_at(input int idx);
    if (idx < beat_q.size()) return beat_q[idx];
    return 9'h1FF;
  endfunction

  // One request on one port; measures busy cycles and bus activity until the done cycle
  task automatic exec_txn(input bit is_inst, input bit wr, input logic [5:0] addr,
                          input logic [31:0] wdata, output logic [127:0] got,
                          output int busy, output int strb, output int rises, output int qs);
    int s0;
    int r0;
    bit done;
    s0 = strobe_cnt;
    r0 = rise_cnt;
    qs = beat_q.size();
    busy = 0;
    got = '0;
    done = 1'b0;
    @(posedge CLK); #1;
    if (is_inst) begin
      i_read = 1'b1; i_address = addr;
    end else begin
      d_read = !wr; d_write = wr; d_address = addr; d_writedata = wdata;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge CLK);
      if (is_inst ? i_busywait : d_busywait) busy++;
      else begin
        done = 1'b1;
        got = is_inst ? i_readdata : {96'b0, d_readdata};
      end
    end
    @(posedge CLK); #1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    check_bit("txn completes", done, 1'b1);
    strb = strobe_cnt - s0;
    rises = rise_cnt - r0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    last_inst = 1'b0;
  endtask

  // Instruction fill plus a data read, the data request arriving d_delay cycles later (0 = together)
  task automatic serve_both(input string name, input int d_delay, input logic [5:0] ia,
                            input logic [5:0] da);
    int cyc = 0;
    int i_done_c = -1;
    int d_done_c = -1;
    int first_i_c = -1;
    int first_d_c = -1;
    int switches = 0;
    bit have_last = 1'b0;
    logic last_reg = 1'b0;
    bit exp_i_first;
    bit got_i_first;
    logic [127:0] i_got = '0;
    logic [31:0]  d_got = '0;
    if (d_delay > 0) exp_i_first = 1'b1;
    else begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_i_first = !last_inst;
`else
      exp_i_first = 1'b0;
`endif
    end
    @(posedge CLK); #1;
    i_read = 1'b1; i_address = ia;
    if (d_delay == 0) begin d_read = 1'b1; d_address = da; end
    while ((i_read || d_read || cyc < d_delay) && cyc < 300) begin
      @(negedge CLK);
      if (mem_read || mem_write) begin
        if (mem_address[8]) begin if (first_d_c < 0) first_d_c = cyc; end
        else if (first_i_c < 0) first_i_c = cyc;
        if (have_last && mem_address[8] != last_reg) switches++;
        last_reg = mem_address[8];
        have_last = 1'b1;
      end
      if (i_read && !i_busywait) begin i_done_c = cyc; i_got = i_readdata; end
      if (d_read && !d_busywait) begin d_done_c = cyc; d_got = d_readdata; end
      @(posedge CLK); #1;
      if (i_done_c == cyc) i_read = 1'b0;
      if (d_done_c == cyc) d_read = 1'b0;
      if (d_delay > 0 && cyc + 1 == d_delay) begin d_read = 1'b1; d_address = da; end
      cyc++;
    end
    i_read = 1'b0; d_read = 1'b0;
    check_bit({name, " i done"}, i_done_c >= 0, 1'b1);
    check_bit({name, " d done"}, d_done_c >= 0, 1'b1);
    got_i_first = (first_i_c >= 0) && (first_d_c < 0 || first_i_c < first_d_c);
    check_bit({name, " inst first"}, got_i_first, exp_i_first);
    check_int({name, " port switches"}, switches, 1);
    if (exp_i_first) check_int({name, " idle gap"}, first_d_c - i_done_c, 2);
    else check_int({name, " idle gap"}, first_i_c - d_done_c, 2);
    check({name, " line"}, i_got, model_line(ia));
    check({name, " word"}, 128'(d_got), 128'(ref_mem[256 + int'(da)]));
    last_inst = !exp_i_first;
  endtask

  typedef struct {
    bit           is_inst;
    bit           wr;
    logic [5:0]   addr;
    logic [31:0]  wdata;
    int           lat;
    bit           chk_data;
    logic [127:0] exp_data;
    int           exp_busy;
    int           exp_strb;
    int           exp_beats;
    logic [8:0]   exp_a0;
  } vec_t;

  vec_t         vt [5];
  logic [127:0] got;
  int           busy, strb, rises, qs, nb, ea;
  bit           is_inst, wr, found;
  logic [5:0]   addr;
  logic [31:0]  wdata;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0; lat = 0; last_inst = 1'b0;

    vt[0] = '{1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 2, 1'b0, 128'h0, 4, 3, 1, 9'h105};
    vt[1] = '{1'b0, 1'b0, 6'h05, 32'h0, 2, 1'b1, 128'hDEADBEEF, 4, 3, 1, 9'h105};
    vt[2] = '{1'b1, 1'b0, 6'h03, 32'h0, 1, 1'b1,
              128'h44444444_33333333_22222222_11111111, 12, 8, 4, 9'h00C};
    vt[3] = '{1'b0, 1'b0, 6'h3F, 32'h0, 0, 1'b1, 128'hA13F013F, 2, 1, 1, 9'h13F};
    vt[4] = '{1'b0, 1'b0, 6'h00, 32'h0, 0, 1'b1, 128'hA1000100, 2, 1, 1, 9'h100};

    // Preload memory while reset is held with both requests raised
    for (int a = 0; a < 512; a++) begin
      @(posedge CLK); #1;
      bd_en = 1'b1; bd_addr = 9'(a); bd_data = pre(a);
      ref_mem[a] = pre(a);
    end
    @(posedge CLK); #1 bd_en = 1'b0;
    @(negedge CLK);
    check_bit("reset i_busywait forced low", i_busywait, 1'b0);
    check_bit("reset d_busywait forced low", d_busywait, 1'b0);
    check_bit("reset mem_read", mem_read, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0; i_read = 1'b0; d_read = 1'b0;
    @(negedge CLK);
    check_bit("post-reset mem_read", mem_read, 1'b0);
    check_bit("post-reset mem_write", mem_write, 1'b0);
    check("post-reset mem_address", 128'(mem_address), 128'(9'h0));
    check("post-reset mem_writedata", 128'(mem_writedata), 128'(32'h0));
    check("post-reset i_readdata", i_readdata, 128'h0);
    check("post-reset d_readdata", 128'(d_readdata), 128'(32'h0));

    for (int v = 0; v < 5; v++) begin
      lat = vt[v].lat;
      exec_txn(vt[v].is_inst, vt[v].wr, vt[v].addr, vt[v].wdata, got, busy, strb, rises, qs);
      if (vt[v].chk_data) check($sformatf("vec%0d data", v), got, vt[v].exp_data);
      check_int($sformatf("vec%0d busy cycles", v), busy, vt[v].exp_busy);
      check_int($sformatf("vec%0d strobe cycles", v), strb, vt[v].exp_strb);
      check_int($sformatf("vec%0d beats", v), beat_q.size() - qs, vt[v].exp_beats);
      check_int($sformatf("vec%0d requests", v), rises, vt[v].exp_beats);
      check($sformatf("vec%0d first addr", v), 128'(q_at(qs)), 128'(vt[v].exp_a0));
      if (vt[v].wr) ref_mem[256 + int'(vt[v].addr)] = vt[v].wdata;
      last_inst = vt[v].is_inst;
    end

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("hold d_readdata", 128'(d_readdata), vt[4].exp_data);
    check("hold i_readdata", i_readdata, vt[2].exp_data);

    for (int n = 0; n < 40; n++) begin
      is_inst = ($urandom_range(0, 2) == 0);
      wr = !is_inst && ($urandom_range(0, 1) == 1);
      addr = 6'($urandom_range(0, 63));
      wdata = $urandom;
      lat = int'($urandom_range(0, 3));
      exec_txn(is_inst, wr, addr, wdata, got, busy, strb, rises, qs);
      nb = is_inst ? 4 : 1;
      if (is_inst) check($sformatf("rnd%0d line", n), got, model_line(addr));
      else if (!wr) check($sformatf("rnd%0d word", n), got, 128'(ref_mem[256 + int'(addr)]));
      check_int($sformatf("rnd%0d busy cycles", n), busy, is_inst ? 4 * (lat + 1) + 4 : lat + 2);
      check_int($sformatf("rnd%0d strobe cycles", n), strb, nb * (lat + 1));
      check_int($sformatf("rnd%0d requests", n), rises, nb);
      check_int($sformatf("rnd%0d beats", n), beat_q.size() - qs, nb);
      for (int k = 0; k < nb; k++) begin
        ea = is_inst ? int'(addr) * 4 + k : 256 + int'(addr);
        check_int($sformatf("rnd%0d beat%0d addr", n, k), int'(q_at(qs + k)), ea);
      end
      if (wr) begin
        ref_mem[256 + int'(addr)] = wdata;
        check($sformatf("rnd%0d stored word", n), 128'(mem[256 + int'(addr)]), 128'(wdata));
      end
      last_inst = is_inst;
    end

    // Reset during beat 1 of a fill
    lat = 1;
    @(posedge CLK); #1;
    i_read = 1'b1; i_address = 6'h03;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge CLK);
      if (mem_read && mem_address == 9'h00D) found = 1'b1;
    end
    check_bit("rst reached beat 1", found, 1'b1);
    @(posedge CLK); #1 RESET = 1'b1;
    @(negedge CLK);
    check_bit("rst i_busywait forced low", i_busywait, 1'b0);
    check_bit("rst mem_read gated", mem_read, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0; i_read = 1'b0; last_inst = 1'b0;
    @(negedge CLK);
    check_bit("rst mem_read after", mem_read, 1'b0);
    check_bit("rst mem_write after", mem_write, 1'b0);
    check("rst mem_address after", 128'(mem_address), 128'(9'h0));
    check("rst i_readdata cleared", i_readdata, 128'h0);
    check("rst d_readdata cleared", 128'(d_readdata), 128'(32'h0));
    exec_txn(1'b1, 1'b0, 6'h03, 32'h0, got, busy, strb, rises, qs);
    check("refill line", got, model_line(6'h03));
    check("refill starts at beat 0", 128'(q_at(qs)), 128'(9'h00C));
    check_int("refill busy cycles", busy, 4 * (lat + 1) + 4);
    last_inst = 1'b1;

    lat = 0;
    pulse_reset();
    serve_both("simul", 0, 6'h03, 6'h05);
    lat = 1;
    serve_both("late_d", 7, 6'h03, 6'h3F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
